stoch_mult_sequencer: RTL and testbench
=======================================

Name: stoch_mult_sequencer

Overview:
Sequences one bipolar stochastic multiply on the LFSR/comparator/XNOR datapath.
- Accepts an operand pair through a ready/start handshake.
- Clears the datapath, then enables it for a fixed bitstream length.
- Counts the '1' bits that come back after the datapath pipeline latency.
- Presents the count as the result, with a one-cycle done pulse.
- Sits between the top-level pin wrapper and the stochastic datapath; the datapath holds no sequencing logic of its own.

Parameters:
- OP_W, 4, width of each operand (comparator threshold).
- LEN_LOG2, 3, bitstream length L = 2^LEN_LOG2 cycles.
- PIPE_LAT, 2, cycles from dp_en high to the matching sn_bit_in sample; legal range 0..7.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- op_a  in  OP_W  operand A; sampled on the accept cycle.
- op_b  in  OP_W  operand B; sampled on the accept cycle.
- ready  out  1  high only in IDLE.
- busy  out  1  high in LOAD, RUN and DRAIN.
- done  out  1  one-cycle pulse in the DONE state.
- result  out  LEN_LOG2+1  count of '1' bits in the last stream; range 0..L.
- dp_clear  out  1  datapath clear: LFSR reseed and SN registers zeroed.
- dp_en  out  1  datapath advance enable.
- dp_op_a  out  OP_W  latched operand A to comparator 1.
- dp_op_b  out  OP_W  latched operand B to comparator 2.
- sn_bit_in  in  1  XNOR output bit from the datapath.

Behaviour:
Clock and reset:
- One clock, clk. rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge, in any state) forces:
  - state=IDLE, ready=1, busy=0, done=0;
  - result=0, dp_clear=0, dp_en=0;
  - dp_op_a=0, dp_op_b=0;
  - stream counter, bit counter and valid delay line all 0.
- Reset during an operation aborts it with no done pulse.

FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: if start=1, latch op_a/op_b into dp_op_a/dp_op_b, clear the bit counter, go to LOAD. Otherwise stay.
- LOAD, 1 cycle: dp_clear=1, dp_en=0. Go to RUN.
- RUN, exactly L cycles: dp_en=1. The stream counter counts 0..L-1 and wraps to 0 on exit.
  - After the last RUN cycle, go to DRAIN if PIPE_LAT>0, else to DONE.
- DRAIN, exactly PIPE_LAT cycles: dp_en=0. Counting continues.
- DONE, 1 cycle: done=1 and result is loaded with the bit counter. Go to IDLE.

Counting:
- dp_en passes through a PIPE_LAT-stage delay line, all zeros after reset and after LOAD.
- On a cycle where the delayed enable is 1 and sn_bit_in=1, the bit counter increments.
- Exactly L samples are counted per operation. The counter is LEN_LOG2+1 bits wide, so it cannot overflow (max = L).

Latency:
- Accept in cycle 0 → done=1 in cycle L+PIPE_LAT+2.
- Default parameters: cycle 12.

Handshake and hold rules:
- start while ready=0 (including the DONE cycle) is ignored and not queued.
- A back-to-back start is accepted in the IDLE cycle right after DONE.
- result holds its value until the next DONE or reset.
- dp_op_a/dp_op_b hold from accept until the next accept.
- op_a/op_b changes after the accept cycle have no effect.

Optional Feature:
Macro: STOCH_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD, RUN or DRAIN goes to IDLE next cycle: no done pulse, result unchanged, dp_en=0, delay line cleared.
  - abort in IDLE or DONE has no effect.
  - abort and rst_n=0 together: reset wins.
- Not defined: no abort port; an operation always runs to DONE.

Test Plan:
1. Reset, then start with op_a=4'hF, op_b=4'hF, sn_bit_in tied 1 → done pulse in cycle 12 after accept; result=8; busy high cycles 1-11; dp_clear high only in cycle 1; dp_en high cycles 2-9.
2. sn_bit_in tied 0 → result=0. Then a second start in the cycle after done is accepted, with ready=1 in that cycle.
3. Bench drives sn_bit_in=1 only in cycles 4,6,8,10 (the delayed-enable window) plus cycles 3 and 12 outside it → result=4 (out-of-window bits ignored).
4. start held high through busy and the DONE cycle → exactly one operation per IDLE visit; no extra done pulse.
5. Assert rst_n=0 in cycle 6 of an operation → next cycle: ready=1, busy=0, result=0, dp_en=0; no done pulse afterwards.
6. With STOCH_SEQ_ABORT_EN: pulse abort in cycle 5 after a previous result=8 → IDLE in cycle 6, no done, result stays 8. Then a new start completes normally.

Source files
------------

// File: rtl/stoch_mult_sequencer.sv
// stoch_mult_sequencer: drives one bipolar stochastic multiply and counts ones.
// Optional abort input enabled by defining STOCH_SEQ_ABORT_EN.
module stoch_mult_sequencer #(
   parameter int OP_W     = 4,
   parameter int LEN_LOG2 = 3,
   parameter int PIPE_LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef STOCH_SEQ_ABORT_EN
   input  logic                abort,
`endif
   input  logic                start,
   input  logic [OP_W-1:0]     op_a,
   input  logic [OP_W-1:0]     op_b,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic [LEN_LOG2:0]   result,
   output logic                dp_clear,
   output logic                dp_en,
   output logic [OP_W-1:0]     dp_op_a,
   output logic [OP_W-1:0]     dp_op_b,
   input  logic                sn_bit_in
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE
   } state_t;

   localparam int CW = LEN_LOG2 + 1;
   localparam int DW = (PIPE_LAT > 0) ? PIPE_LAT : 1;
   localparam logic [LEN_LOG2-1:0] S_LAST = '1;
   localparam logic [2:0] D_LAST =
      (PIPE_LAT > 0) ? 3'(PIPE_LAT - 1) : 3'd0;

   state_t              state, state_nx;
   logic [LEN_LOG2-1:0] scnt;
   logic [2:0]          dcnt;
   logic [CW-1:0]       bcnt;
   logic [DW-1:0]       en_dly;
   logic                en_out;
   logic                accept;
   logic                abort_hit;

`ifdef STOCH_SEQ_ABORT_EN
   assign abort_hit = abort & busy;
`else
   assign abort_hit = 1'b0;
`endif

   assign accept = ready & start;

   // Sample whose enable left the datapath PIPE_LAT cycles ago
   generate
      if (PIPE_LAT == 0) begin : g_nolat
         assign en_out = dp_en;
      end else begin : g_lat
         assign en_out = en_dly[DW-1];
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_LOAD;
         S_LOAD:  state_nx = S_RUN;
         S_RUN:   if (scnt == S_LAST)
                     state_nx = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
         S_DRAIN: if (dcnt == D_LAST) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (abort_hit) state_nx = S_IDLE;
   end

   // Per-state outputs
   always_comb begin
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      dp_clear = 1'b0;
      dp_en    = 1'b0;
      unique case (state)
         S_IDLE:  ready = 1'b1;
         S_LOAD:  begin busy = 1'b1; dp_clear = 1'b1; end
         S_RUN:   begin busy = 1'b1; dp_en = 1'b1; end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Stream and drain counters, zero outside their own state
   always_ff @(posedge clk) begin
      if (!rst_n || abort_hit) begin
         scnt <= '0;
         dcnt <= '0;
      end else begin
         scnt <= (state == S_RUN) ? scnt + LEN_LOG2'(1) : '0;
         dcnt <= (state == S_DRAIN) ? dcnt + 3'd1 : 3'd0;
      end
   end

   // Enable delay line, flushed on LOAD so stale enables never count
   always_ff @(posedge clk) begin
      if (!rst_n || abort_hit || state == S_LOAD)
         en_dly <= '0;
      else
         en_dly <= (en_dly << 1) | DW'(dp_en);
   end

   // Ones counter over the aligned sample window
   always_ff @(posedge clk) begin
      if (!rst_n)                  bcnt <= '0;
      else if (accept)             bcnt <= '0;
      else if (en_out & sn_bit_in) bcnt <= bcnt + CW'(1);
   end

   // Operand latch and result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dp_op_a <= '0;
         dp_op_b <= '0;
         result  <= '0;
      end else begin
         if (accept) begin
            dp_op_a <= op_a;
            dp_op_b <= op_b;
         end
         if (state == S_DONE) result <= bcnt;
      end
   end

endmodule

// File: tb/tb_stoch_mult_sequencer.sv
// tb_stoch_mult_sequencer: vector table, random ops vs. window-count model.
// Abort sequence compiled in only with STOCH_SEQ_ABORT_EN.
module tb_stoch_mult_sequencer;

   localparam int OP_W = 4;
   localparam int LEN_LOG2 = 3;
   localparam int PIPE_LAT = 2;
   localparam int L = 1 << LEN_LOG2;
   localparam int T_DONE = L + PIPE_LAT + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [OP_W-1:0] op_a = '0;
   logic [OP_W-1:0] op_b = '0;
   logic sn_bit_in = 1'b0;
   logic ready, busy, done, dp_clear, dp_en;
   logic [LEN_LOG2:0] result;
   logic [OP_W-1:0] dp_op_a, dp_op_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stoch_mult_sequencer #(
      .OP_W(OP_W), .LEN_LOG2(LEN_LOG2), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef STOCH_SEQ_ABORT_EN
      .abort(abort),
`endif
      .start(start),
      .op_a(op_a),
      .op_b(op_b),
      .ready(ready),
      .busy(busy),
      .done(done),
      .result(result),
      .dp_clear(dp_clear),
      .dp_en(dp_en),
      .dp_op_a(dp_op_a),
      .dp_op_b(dp_op_b),
      .sn_bit_in(sn_bit_in)
   );

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic [15:0] mask;
      logic        hold;
      int          exp_res;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic [15:0] rng(input int lo, input int hi);
      logic [15:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Samples in cycles PIPE_LAT+2 .. PIPE_LAT+L+1 are the counted ones
   function automatic int model(input logic [15:0] mask);
      int n = 0;
      for (int c = 0; c < 16; c++)
         if (c >= PIPE_LAT + 2 && c <= PIPE_LAT + L + 1 && mask[c]) n++;
      return n;
   endfunction

   // Entered mid-cycle (negedge) of the accept cycle; leaves mid-cycle
   // of the IDLE cycle after DONE.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [15:0] mask, input logic hold,
                         input int exp_res, input string tag);
      logic [15:0] v_done = '0, v_busy = '0, v_clr = '0;
      logic [15:0] v_en = '0, v_rdy = '0;
      for (int c = 0; c <= T_DONE; c++) begin
         start = (c == 0) || hold;
         op_a = (c == 0) ? a : 4'($urandom);
         op_b = (c == 0) ? b : 4'($urandom);
         sn_bit_in = mask[c];
         v_done[c] = done;
         v_busy[c] = busy;
         v_clr[c] = dp_clear;
         v_en[c] = dp_en;
         v_rdy[c] = ready;
         @(negedge clk);
      end
      start = 1'b0;
      sn_bit_in = 1'b0;
      chk({tag, ".done"}, int'(v_done), int'(rng(T_DONE, T_DONE)));
      chk({tag, ".busy"}, int'(v_busy), int'(rng(1, T_DONE - 1)));
      chk({tag, ".clear"}, int'(v_clr), int'(rng(1, 1)));
      chk({tag, ".en"}, int'(v_en), int'(rng(2, L + 1)));
      chk({tag, ".ready"}, int'(v_rdy), int'(rng(0, 0)));
      chk({tag, ".result"}, int'(result), exp_res);
      chk({tag, ".ready_after"}, int'(ready), 1);
      chk({tag, ".op_a"}, int'(dp_op_a), int'(a));
      chk({tag, ".op_b"}, int'(dp_op_b), int'(b));
   endtask

   vec_t vt[6];
   int nd;

   initial begin
      vt[0] = '{4'hF, 4'hF, 16'hFFFF, 1'b0, 8};
      vt[1] = '{4'h0, 4'h0, 16'h0000, 1'b0, 0};
      vt[2] = '{4'h3, 4'hA, 16'h1558, 1'b0, 4};
      vt[3] = '{4'h5, 4'h5, 16'hFFFF, 1'b1, 8};
      vt[4] = '{4'h9, 4'h6, 16'hF00F, 1'b0, 0};
      vt[5] = '{4'hC, 4'h1, 16'h0A50, 1'b0, 4};

      repeat (3) @(negedge clk);
      chk("rst.ready", int'(ready), 1);
      chk("rst.busy", int'(busy), 0);
      chk("rst.done", int'(done), 0);
      chk("rst.result", int'(result), 0);
      chk("rst.dp_clear", int'(dp_clear), 0);
      chk("rst.dp_en", int'(dp_en), 0);
      chk("rst.dp_op_a", int'(dp_op_a), 0);
      chk("rst.dp_op_b", int'(dp_op_b), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table ops run back-to-back: each starts in the IDLE after DONE
      for (int i = 0; i < 6; i++)
         run_op(vt[i].a, vt[i].b, vt[i].mask, vt[i].hold,
                vt[i].exp_res, $sformatf("vec%0d", i));

      for (int i = 0; i < 10; i++) begin
         logic [3:0] a = 4'($urandom);
         logic [3:0] b = 4'($urandom);
         logic [15:0] m = 16'($urandom);
         run_op(a, b, m, 1'b0, model(m), $sformatf("rnd%0d", i));
      end

      // Reset in cycle 6 of an operation after a result of 8
      run_op(4'hF, 4'hF, 16'hFFFF, 1'b0, 8, "pre_rst");
      for (int c = 0; c < 6; c++) begin
         start = (c == 0);
         op_a = 4'h7;
         op_b = 4'h2;
         sn_bit_in = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst.ready", int'(ready), 1);
      chk("mid_rst.busy", int'(busy), 0);
      chk("mid_rst.result", int'(result), 0);
      chk("mid_rst.dp_en", int'(dp_en), 0);
      nd = 0;
      for (int c = 0; c < 16; c++) begin
         nd += int'(done);
         @(negedge clk);
      end
      chk("mid_rst.no_done", nd, 0);
      sn_bit_in = 1'b0;
      run_op(4'h2, 4'hD, 16'h0FF0, 1'b0, 8, "post_rst");

`ifdef STOCH_SEQ_ABORT_EN
      run_op(4'hF, 4'hF, 16'hFFFF, 1'b0, 8, "pre_abort");
      for (int c = 0; c < 6; c++) begin
         start = (c == 0);
         abort = (c == 5);
         op_a = 4'h4;
         op_b = 4'h8;
         sn_bit_in = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      chk("abort.ready", int'(ready), 1);
      chk("abort.busy", int'(busy), 0);
      chk("abort.dp_en", int'(dp_en), 0);
      nd = 0;
      for (int c = 0; c < 16; c++) begin
         nd += int'(done);
         @(negedge clk);
      end
      chk("abort.no_done", nd, 0);
      chk("abort.result", int'(result), 8);
      run_op(4'h6, 4'h3, 16'h0550, 1'b0, 4, "post_abort");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
